// File: rtl/scan_mux_n.sv
// scan_mux_n: registered N-channel W-bit mux with manual select and
// round-robin auto-scan; data_out/chan_out/valid/wrap are registered together.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   data_in       packed channels, channel k = data_in[k*WIDTH +: WIDTH]
//   mode          0 = manual (sel), 1 = auto-scan
//   sel           manual channel select (out-of-range values hold)
//   dwell         scan: cycles per channel = dwell+1
//   hold          scan: freeze channel advance
//   chan_mask     per-channel enable, only with SCAN_MUX_MASK_EN defined
//   data_out      registered selected data
//   chan_out      registered index of the channel driving data_out
//   valid         data_out/chan_out meaningful
//   wrap          one-cycle pulse when scan wraps past the last channel
// Build option: define SCAN_MUX_MASK_EN to add the chan_mask input.
module scan_mux_n #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      hold,
`ifdef SCAN_MUX_MASK_EN
  input  logic [CHANNELS-1:0]       chan_mask,
`endif
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      valid,
  output logic                      wrap
);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN,
    PAUSE
  } state_t;

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]     chan_q, chan_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;

  logic [CHANNELS-1:0]  msk;
  logic [WIDTH-1:0]     ch [CHANNELS];
  logic [SEL_W-1:0]     man_chan;
  logic [SEL_W-1:0]     nxt_chan;
  logic                 nxt_wrap;
  logic                 nxt_any;

`ifdef SCAN_MUX_MASK_EN
  assign msk = chan_mask;
`else
  assign msk = '1;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Out-of-range select keeps the current channel.
  always_comb begin
    man_chan = chan_q;
    if (int'(sel) < CHANNELS) man_chan = sel;
  end

  // Next enabled channel above chan_q. Offsets are scanned from the far
  // end down so the nearest hit wins; an offset that crosses the last
  // index is a wrap (a lone enabled channel finds itself with wrap=1).
  always_comb begin
    nxt_chan = chan_q;
    nxt_wrap = 1'b0;
    nxt_any  = 1'b0;
    for (int i = CHANNELS; i >= 1; i--) begin
      if (int'(chan_q) + i >= CHANNELS) begin
        if (msk[SEL_W'(int'(chan_q) + i - CHANNELS)]) begin
          nxt_any  = 1'b1;
          nxt_chan = SEL_W'(int'(chan_q) + i - CHANNELS);
          nxt_wrap = 1'b1;
        end
      end else if (msk[SEL_W'(int'(chan_q) + i)]) begin
        nxt_any  = 1'b1;
        nxt_chan = SEL_W'(int'(chan_q) + i);
        nxt_wrap = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mode) begin
          state_d = SCAN;
        end else begin
          state_d = MANUAL;
          chan_d  = man_chan;
        end
      end
      MANUAL: begin
        cnt_d = '0;
        if (mode) state_d = SCAN;
        else      chan_d  = man_chan;
      end
      SCAN, PAUSE: begin
        if (!mode) begin
          state_d = MANUAL;
          chan_d  = man_chan;
          cnt_d   = '0;
        end else if (hold) begin
          state_d = PAUSE;
        end else begin
          state_d = SCAN;
          // >= so a dwell lowered below the count advances at once.
          if (cnt_q >= dwell) begin
            cnt_d = '0;
            if (nxt_any) begin
              chan_d = nxt_chan;
              wrap_d = nxt_wrap;
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // IDLE never lasts past one edge, so every edge leaving reset
    // samples the channel being written on that same edge.
    valid_d = msk[chan_d];
    data_d  = msk[chan_d] ? ch[chan_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign data_out = data_q;
  assign chan_out = chan_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// tb_scan_mux_n: directed bench for scan_mux_n with a 4-channel and a
// 5-channel instance (both WIDTH=4) sharing one clock.
module tb_scan_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic        rst4;
  logic [15:0] din4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [7:0]  dwell4;
  logic        hold4;
  logic [3:0]  mask4;
  logic [3:0]  dout4;
  logic [1:0]  chan4;
  logic        valid4;
  logic        wrap4;

  logic        rst5;
  logic [19:0] din5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  dwell5;
  logic        hold5;
  logic [4:0]  mask5;
  logic [3:0]  dout5;
  logic [2:0]  chan5;
  logic        valid5;
  logic        wrap5;

  scan_mux_n #(.WIDTH(4), .CHANNELS(4)) u4 (
    .clk      (clk),
    .reset    (rst4),
    .data_in  (din4),
    .mode     (mode4),
    .sel      (sel4),
    .dwell    (dwell4),
    .hold     (hold4),
`ifdef SCAN_MUX_MASK_EN
    .chan_mask(mask4),
`endif
    .data_out (dout4),
    .chan_out (chan4),
    .valid    (valid4),
    .wrap     (wrap4)
  );

  scan_mux_n #(.WIDTH(4), .CHANNELS(5)) u5 (
    .clk      (clk),
    .reset    (rst5),
    .data_in  (din5),
    .mode     (mode5),
    .sel      (sel5),
    .dwell    (dwell5),
    .hold     (hold5),
`ifdef SCAN_MUX_MASK_EN
    .chan_mask(mask5),
`endif
    .data_out (dout5),
    .chan_out (chan5),
    .valid    (valid5),
    .wrap     (wrap5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1;
    tick();
    checks++;
    if ({dout4, chan4, valid4, wrap4} !== 8'h00) begin
      $display("FAIL reset_init: got d=%h c=%0d v=%b w=%b want all 0",
               dout4, chan4, valid4, wrap4);
      fails++;
    end
    rst4 = 1'b0; mode4 = 1'b1; dwell4 = 8'd0;
    din4 = 16'h4321;
    tick(); tick(); tick();
    checks++;
    if (chan4 !== 2'd2) begin
      $display("FAIL pre_reset_scan: chan got %0d want 2", chan4);
      fails++;
    end
    rst4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dout4, chan4, valid4, wrap4} !== 8'h00) begin
        $display("FAIL reset_mid_scan%0d: got d=%h c=%0d v=%b w=%b want 0",
                 i, dout4, chan4, valid4, wrap4);
        fails++;
      end
    end
    rst4 = 1'b0; mode4 = 1'b0; sel4 = 2'd2;
    tick();
    checks++;
    if (valid4 !== 1'b1 || chan4 !== 2'd2 || dout4 !== 4'h3) begin
      $display("FAIL reset_release: got v=%b c=%0d d=%h want v=1 c=2 d=3",
               valid4, chan4, dout4);
      fails++;
    end
  endtask

  task automatic test_manual();
    din4 = 16'hDCBA; sel4 = 2'd0;
    tick();
    checks++;
    if (dout4 !== 4'hA || chan4 !== 2'd0) begin
      $display("FAIL manual_sel0: got d=%h c=%0d want d=a c=0", dout4, chan4);
      fails++;
    end
    sel4 = 2'd3;
    #2;
    checks++;
    if (dout4 !== 4'hA) begin
      $display("FAIL manual_before_edge: got %h want a", dout4);
      fails++;
    end
    tick();
    checks++;
    if (dout4 !== 4'hD || chan4 !== 2'd3) begin
      $display("FAIL manual_sel3: got d=%h c=%0d want d=d c=3", dout4, chan4);
      fails++;
    end
    din4 = 16'h5CBA;
    #2;
    checks++;
    if (dout4 !== 4'hD) begin
      $display("FAIL manual_data_hold: got %h want d", dout4);
      fails++;
    end
    tick();
    checks++;
    if (dout4 !== 4'h5) begin
      $display("FAIL manual_data_lat: got %h want 5", dout4);
      fails++;
    end
  endtask

  task automatic test_scan_wrap();
    int seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int fast [5] = '{1, 2, 3, 0, 1};
    din4 = 16'h4321; sel4 = 2'd0;
    tick();
    mode4 = 1'b1; dwell4 = 8'd2; hold4 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (chan4 !== 2'(seq[i]) || wrap4 !== (i == 12) ||
          dout4 !== 4'(seq[i] + 1) || valid4 !== 1'b1) begin
        $display("FAIL scan_d2_%0d: got c=%0d w=%b d=%h v=%b want c=%0d w=%b d=%h v=1",
                 i, chan4, wrap4, dout4, valid4, seq[i], (i == 12), seq[i] + 1);
        fails++;
      end
    end
    dwell4 = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (chan4 !== 2'(fast[i]) || wrap4 !== (i == 3)) begin
        $display("FAIL scan_d0_%0d: got c=%0d w=%b want c=%0d w=%b",
                 i, chan4, wrap4, fast[i], (i == 3));
        fails++;
      end
    end
  endtask

  task automatic test_hold();
    dwell4 = 8'd2;
    tick();
    hold4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din4 = 16'(i + 6) << 4;
      tick();
      checks++;
      if (chan4 !== 2'd1 || dout4 !== 4'(i + 6) || valid4 !== 1'b1) begin
        $display("FAIL hold_%0d: got c=%0d d=%h v=%b want c=1 d=%h v=1",
                 i, chan4, dout4, valid4, i + 6);
        fails++;
      end
    end
    hold4 = 1'b0;
    din4 = 16'h4321;
    tick();
    checks++;
    if (chan4 !== 2'd1) begin
      $display("FAIL resume_1: got c=%0d want 1", chan4);
      fails++;
    end
    tick();
    checks++;
    if (chan4 !== 2'd2 || dout4 !== 4'h3) begin
      $display("FAIL resume_2: got c=%0d d=%h want c=2 d=3", chan4, dout4);
      fails++;
    end
    mode4 = 1'b0; hold4 = 1'b1; sel4 = 2'd3;
    tick();
    checks++;
    if (chan4 !== 2'd3 || dout4 !== 4'h4 || valid4 !== 1'b1) begin
      $display("FAIL mode_over_hold: got c=%0d d=%h v=%b want c=3 d=4 v=1",
               chan4, dout4, valid4);
      fails++;
    end
    hold4 = 1'b0;
  endtask

  task automatic test_out_of_range();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    rst5 = 1'b0; mode5 = 1'b0; sel5 = 3'd3; din5 = 20'h43210;
    tick();
    checks++;
    if (chan5 !== 3'd3 || dout5 !== 4'h3 || valid5 !== 1'b1) begin
      $display("FAIL oor_sel3: got c=%0d d=%h v=%b want c=3 d=3 v=1",
               chan5, dout5, valid5);
      fails++;
    end
    sel5 = 3'd6;
    tick();
    checks++;
    if (chan5 !== 3'd3 || dout5 !== 4'h3) begin
      $display("FAIL oor_sel6: got c=%0d d=%h want c=3 d=3", chan5, dout5);
      fails++;
    end
    sel5 = 3'd4;
    tick();
    checks++;
    if (chan5 !== 3'd4 || dout5 !== 4'h4) begin
      $display("FAIL oor_sel4: got c=%0d d=%h want c=4 d=4", chan5, dout5);
      fails++;
    end
    sel5 = 3'd7;
    tick();
    checks++;
    if (chan5 !== 3'd4) begin
      $display("FAIL oor_sel7: got c=%0d want 4", chan5);
      fails++;
    end
    sel5 = 3'd0;
    tick();
    mode5 = 1'b1; dwell5 = 8'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (chan5 !== 3'(seq[i]) || wrap5 !== (i == 5) || dout5 !== 4'(seq[i])) begin
        $display("FAIL scan5_%0d: got c=%0d w=%b d=%h want c=%0d w=%b d=%h",
                 i, chan5, wrap5, dout5, seq[i], (i == 5), seq[i]);
        fails++;
      end
    end
  endtask

`ifdef SCAN_MUX_MASK_EN
  task automatic test_mask();
    int seq [5] = '{1, 3, 1, 3, 1};
    mode4 = 1'b0; sel4 = 2'd1; mask4 = 4'b1010; din4 = 16'h4321;
    tick();
    mode4 = 1'b1; dwell4 = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (chan4 !== 2'(seq[i]) || wrap4 !== (i == 2 || i == 4)) begin
        $display("FAIL mask_scan_%0d: got c=%0d w=%b want c=%0d w=%b",
                 i, chan4, wrap4, seq[i], (i == 2 || i == 4));
        fails++;
      end
    end
    mask4 = 4'b0000;
    tick();
    checks++;
    if (valid4 !== 1'b0 || dout4 !== 4'h0) begin
      $display("FAIL mask_none: got v=%b d=%h want v=0 d=0", valid4, dout4);
      fails++;
    end
    mask4 = 4'b1111;
  endtask
`endif

  initial begin
    rst4 = 1'b1; din4 = '0; mode4 = 1'b0; sel4 = '0;
    dwell4 = '0; hold4 = 1'b0; mask4 = '1;
    rst5 = 1'b1; din5 = '0; mode5 = 1'b0; sel5 = '0;
    dwell5 = '0; hold5 = 1'b0; mask5 = '1;
    test_reset();
    test_manual();
    test_scan_wrap();
    test_hold();
    test_out_of_range();
`ifdef SCAN_MUX_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/scan_mux_n.md
Name: scan_mux_n

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; successor to the board-level 4-to-1 single-bit mux.
- Two modes:
  - Manual: the channel is chosen by a select input.
  - Auto-scan: a dwell counter steps through channels round-robin.
- Output data and current channel index are registered together, so a display or downstream stage always sees a consistent pair.
- Sits between switch/sensor inputs and the LEDR/HEX display logic on the lab board.

Parameters:
- WIDTH, 1, bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), select/index width (derived; do not override).
- DWELL_W, 8, width of dwell-count input and internal counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  CHANNELS*WIDTH  packed channel data; channel k = data_in[k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = auto-scan.
- sel  input  SEL_W  manual channel select.
- dwell  input  DWELL_W  scan: cycles spent on each channel = dwell+1.
- hold  input  1  scan: freeze channel advance.
- data_out  output  WIDTH  registered selected data.
- chan_out  output  SEL_W  registered index of channel driving data_out.
- valid  output  1  data_out/chan_out meaningful.
- wrap  output  1  one-cycle pulse when scan advances from last channel to channel 0.

Behaviour:
- Reset (reset=1 at clock edge, priority over everything):
  - data_out=0, chan_out=0, valid=0, wrap=0, dwell counter=0, state=IDLE.
  - Reset mid-scan abandons position; the next scan restarts at channel 0.
- States: IDLE, MANUAL, SCAN, PAUSE.
- IDLE:
  - Outputs hold reset values.
  - Next edge: mode=0 -> MANUAL, mode=1 -> SCAN.
  - On that transition edge: chan_out and data_out load per the target state's rule; valid<=1.
- Every edge outside IDLE:
  - data_out <= data_in slice of the chan_out value written on that same edge.
  - Latency from data_in or sel change to data_out is exactly 1 cycle.
- MANUAL:
  - chan_out <= sel if sel < CHANNELS; otherwise chan_out holds its previous value (no X, no wrap).
  - Counter held at 0.
  - mode=1 -> SCAN; scanning starts from the current chan_out and the counter restarts at 0.
- SCAN:
  - Counter increments each cycle.
  - When counter == dwell: counter<=0 and chan_out <= chan_out+1, wrapping CHANNELS-1 -> 0.
  - The wrap edge sets wrap=1 for exactly one cycle; wrap=0 at all other times.
  - dwell=0 -> advance every cycle.
  - dwell changed mid-dwell: the new value is compared from the next cycle.
  - If the counter already exceeds the new dwell, the advance occurs on the next edge and the counter clears.
  - hold=1 -> PAUSE. mode=0 -> MANUAL. If both, mode wins.
- PAUSE:
  - Counter and chan_out frozen; data_out keeps resampling data_in of chan_out each cycle.
  - hold=0 -> SCAN, resuming with the frozen counter value. mode=0 -> MANUAL.
- valid=1 in MANUAL, SCAN and PAUSE.
- Non-power-of-two CHANNELS: the wrap compare is against CHANNELS-1, never 2^SEL_W-1.

Optional Feature:
- Macro: SCAN_MUX_MASK_EN.
- Defined:
  - Adds input chan_mask [CHANNELS]; bit k=1 enables channel k.
  - Scan advance goes to the next enabled index above chan_out, wrapping to the lowest enabled; wrap pulses when the search passes index CHANNELS-1.
  - Single enabled channel: chan_out stays on it, and wrap pulses every dwell+1 cycles.
  - All bits 0 in SCAN/PAUSE: chan_out holds, valid=0, data_out=0; valid returns to 1 on the first advance after a bit is set.
  - MANUAL select of a masked channel: chan_out=sel, data_out=0, valid=0.
- Undefined: port absent; all channels enabled; behaviour exactly as above.

Test Plan:
- Reset: assert reset 3 cycles mid-scan with WIDTH=4, CHANNELS=4 -> data_out=0, chan_out=0, valid=0, wrap=0; after release with mode=0, sel=2, data_in=16'h4321 -> next edge valid=1, chan_out=2, data_out=4'h3.
- Manual latency: WIDTH=4, CHANNELS=4, data_in=16'hDCBA; sel 0->3 at edge n -> data_out=A until edge n+1, then D, chan_out=3. Change data_in[15:12] to 5 -> data_out=5 one cycle later.
- Scan/wrap: mode=1, dwell=2, start chan 0 -> chan_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap=1 only in the cycle chan_out first shows 0 again. dwell=0 -> chan_out changes every cycle.
- Hold/mode priority: hold=1 for 5 cycles mid-dwell (counter=1) -> chan_out frozen, data_out tracks data_in. On hold=0, advance occurs after 2 more cycles (dwell=2). mode=0 and hold=1 together -> MANUAL, chan_out=sel.
- Out-of-range: CHANNELS=5 (SEL_W=3). Manual sel=6 -> chan_out holds previous value. Scan dwell=0 -> 0,1,2,3,4,0 with wrap on the 4->0 edge.
- SCAN_MUX_MASK_EN: CHANNELS=4, chan_mask=4'b1010, dwell=0 -> chan_out 1,3,1,3, wrap on each 3->1. chan_mask=0 -> valid=0, data_out=0 next cycle.
